// File: rtl/axi_rd_arbiter_if.sv
// AXI4-Lite read channel bundle (AR + R) used for both requester ports and the shared memory port.
interface axi_rd_arbiter_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, arprot, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arprot, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4-Lite read arbiter, one outstanding read at a time.
// Define AXI_RD_ARB_RR_EN for round-robin on collisions; default is fixed priority to requester 0.
module axi_rd_arbiter (
  input  logic             clk,
  input  logic             reset,
  axi_rd_arbiter_if.slave  s0_axi,
  axi_rd_arbiter_if.slave  s1_axi,
  axi_rd_arbiter_if.master m_axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_grant;
  logic        r_lastGrant;
  logic        w_nextGrant;
  logic        w_pick;

  logic        w_mArvalid;
  logic [31:0] w_mAraddr;
  logic [2:0]  w_mArprot;
  logic        w_mRready;
  logic        w_s0Arready;
  logic        w_s1Arready;
  logic        w_s0Rvalid;
  logic        w_s1Rvalid;
  logic [31:0] w_s0Rdata;
  logic [31:0] w_s1Rdata;
  logic [1:0]  w_s0Rresp;
  logic [1:0]  w_s1Rresp;

  // Requester chosen when leaving IDLE; only meaningful while at least one arvalid is high.
`ifdef AXI_RD_ARB_RR_EN
  assign w_pick = (s0_axi.arvalid && s1_axi.arvalid) ? ~r_lastGrant : ~s0_axi.arvalid;
`else
  assign w_pick = ~s0_axi.arvalid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      if (r_state == IDLE && w_nextState == ADDR)
        r_lastGrant <= w_nextGrant;
      else
        r_lastGrant <= r_lastGrant;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_mArvalid  = 1'b0;
    w_mAraddr   = '0;
    w_mArprot   = '0;
    w_mRready   = 1'b0;
    w_s0Arready = 1'b0;
    w_s1Arready = 1'b0;
    w_s0Rvalid  = 1'b0;
    w_s1Rvalid  = 1'b0;
    w_s0Rdata   = '0;
    w_s1Rdata   = '0;
    w_s0Rresp   = '0;
    w_s1Rresp   = '0;
    case (r_state)
      IDLE: begin
        if (s0_axi.arvalid || s1_axi.arvalid) begin
          w_nextState = ADDR;
          w_nextGrant = w_pick;
        end
      end
      ADDR: begin
        w_mArvalid  = 1'b1;
        w_mAraddr   = r_grant ? s1_axi.araddr : s0_axi.araddr;
        w_mArprot   = r_grant ? s1_axi.arprot : s0_axi.arprot;
        w_s0Arready = ~r_grant & m_axi.arready;
        w_s1Arready = r_grant & m_axi.arready;
        if (m_axi.arready)
          w_nextState = DATA;
      end
      DATA: begin
        // Error responses pass straight through; the arbiter never creates its own.
        if (r_grant) begin
          w_s1Rvalid = m_axi.rvalid;
          w_s1Rdata  = m_axi.rdata;
          w_s1Rresp  = m_axi.rresp;
          w_mRready  = s1_axi.rready;
        end else begin
          w_s0Rvalid = m_axi.rvalid;
          w_s0Rdata  = m_axi.rdata;
          w_s0Rresp  = m_axi.rresp;
          w_mRready  = s0_axi.rready;
        end
        if (m_axi.rvalid && w_mRready)
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign m_axi.arvalid  = w_mArvalid;
  assign m_axi.araddr   = w_mAraddr;
  assign m_axi.arprot   = w_mArprot;
  assign m_axi.rready   = w_mRready;
  assign s0_axi.arready = w_s0Arready;
  assign s1_axi.arready = w_s1Arready;
  assign s0_axi.rvalid  = w_s0Rvalid;
  assign s1_axi.rvalid  = w_s1Rvalid;
  assign s0_axi.rdata   = w_s0Rdata;
  assign s1_axi.rdata   = w_s1Rdata;
  assign s0_axi.rresp   = w_s0Rresp;
  assign s1_axi.rresp   = w_s1Rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table plus backpressure and reset corner cases.
// Collision expectations follow AXI_RD_ARB_RR_EN when it is defined.
module tb_axi_rd_arbiter;

  typedef struct {
    logic        s0Valid;
    logic [31:0] s0Addr;
    logic [2:0]  s0Prot;
    logic        s1Valid;
    logic [31:0] s1Addr;
    logic [2:0]  s1Prot;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        expGrant;
  } vec_t;

  typedef struct {
    logic        grant;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

`ifdef AXI_RD_ARB_RR_EN
  localparam logic [3:0] COLL_GRANTS = 4'b1010;
`else
  localparam logic [3:0] COLL_GRANTS = 4'b0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  int   xferCount   = 0;
  exp_t sb[$];
  vec_t vecs[9];

  axi_rd_arbiter_if s0Bus ();
  axi_rd_arbiter_if s1Bus ();
  axi_rd_arbiter_if mBus ();

  axi_rd_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .s0_axi (s0Bus),
    .s1_axi (s1Bus),
    .m_axi  (mBus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, {mBus.arvalid, mBus.araddr, mBus.arprot, mBus.rready,
                       s0Bus.arready, s0Bus.rvalid, s0Bus.rdata, s0Bus.rresp,
                       s1Bus.arready, s1Bus.rvalid, s1Bus.rdata, s1Bus.rresp}, 128'd0);
  endtask

  // Waits (bounded) for a routed read response, then pops the scoreboard and compares it.
  task automatic collectResponse(input int budget);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      #1;
      if (s0Bus.rvalid || s1Bus.rvalid) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rvalid_seen", seen, 1'b1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    if (seen) begin
      checkOutput("rvalid_owner", {s1Bus.rvalid, s0Bus.rvalid}, e.grant ? 2'b10 : 2'b01);
      checkOutput("rdata_rresp", e.grant ? {s1Bus.rdata, s1Bus.rresp} : {s0Bus.rdata, s0Bus.rresp},
                  {e.data, e.resp});
      checkOutput("loser_r_zero", e.grant ? {s0Bus.rvalid, s0Bus.rdata, s0Bus.rresp}
                                          : {s1Bus.rvalid, s1Bus.rdata, s1Bus.rresp}, 35'd0);
      checkOutput("m_rready", mBus.rready, 1'b1);
      if (mBus.rvalid && mBus.rready) xferCount++;
    end
  endtask

  // One complete read for a table vector; called on a falling edge with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   n;
    s0Bus.arvalid = v.s0Valid;
    s0Bus.araddr  = v.s0Addr;
    s0Bus.arprot  = v.s0Prot;
    s1Bus.arvalid = v.s1Valid;
    s1Bus.araddr  = v.s1Addr;
    s1Bus.arprot  = v.s1Prot;
    s0Bus.rready  = 1'b1;
    s1Bus.rready  = 1'b1;
    mBus.arready  = 1'b1;
    mBus.rvalid   = 1'b0;
    e.grant = v.expGrant;
    e.addr  = v.expGrant ? v.s1Addr : v.s0Addr;
    e.prot  = v.expGrant ? v.s1Prot : v.s0Prot;
    e.data  = v.data;
    e.resp  = v.resp;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!mBus.arvalid && n < 6);
    checkOutput("ar_latency", n, 1);
    checkOutput("m_araddr_arprot", {mBus.arprot, mBus.araddr}, {e.prot, e.addr});
    checkOutput("s_arready", {s1Bus.arready, s0Bus.arready}, e.grant ? 2'b10 : 2'b01);
    @(negedge clk);
    if (e.grant) s1Bus.arvalid = 1'b0;
    else         s0Bus.arvalid = 1'b0;
    mBus.rvalid = 1'b1;
    mBus.rdata  = v.data;
    mBus.rresp  = v.resp;
    collectResponse(4);
    @(negedge clk);
    mBus.rvalid = 1'b0;
    #1;
    checkIdle("idle_after_read");
  endtask

  initial begin
    exp_t e;
    vec_t v;
    vecs[0] = '{1'b1, 32'h0000_0100, 3'b000, 1'b0, 32'h0,         3'b000, 32'hDEAD_BEEF, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         3'b000, 1'b1, 32'h2000_0040, 3'b100, 32'h1234_5678, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 32'h0,         3'b000, 1'b1, 32'h2000_0044, 3'b001, 32'h0BAD_F00D, 2'b11, 1'b1};
    for (int i = 0; i < 4; i++)
      vecs[3+i] = '{1'b1, 32'h0000_1000 + 32'(i*4), 3'b010, 1'b1, 32'h8000_2000 + 32'(i*4), 3'b110,
                    32'hA5A5_0000 + 32'(i), 2'b00, COLL_GRANTS[i]};
    vecs[7] = '{1'b0, 32'h0,         3'b000, 1'b1, 32'h8000_2010, 3'b110, 32'h5A5A_5A5A, 2'b01, 1'b1};
    vecs[8] = '{1'b1, 32'hFFFF_FFFC, 3'b111, 1'b0, 32'h0,         3'b000, 32'hFFFF_FFFF, 2'b00, 1'b0};

    reset = 1'b1;
    {s0Bus.arvalid, s0Bus.araddr, s0Bus.arprot, s0Bus.rready} = '0;
    {s1Bus.arvalid, s1Bus.araddr, s1Bus.arprot, s1Bus.rready} = '0;
    {mBus.arready, mBus.rdata, mBus.rresp, mBus.rvalid} = '0;
    repeat (2) @(negedge clk);
    #1;
    checkIdle("during_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkIdle("after_reset");

    for (int i = 0; i < 9; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end
    s0Bus.arvalid = 1'b0;
    s1Bus.arvalid = 1'b0;

    // Backpressure: address stall for 5 cycles, then requester data stall for 3 cycles.
    $display("[TB] backpressure sequence");
    @(negedge clk);
    xferCount = 0;
    s1Bus.arvalid = 1'b1;
    s1Bus.araddr  = 32'h0000_3000;
    s1Bus.arprot  = 3'b010;
    mBus.arready  = 1'b0;
    e = '{1'b1, 32'h0000_3000, 3'b010, 32'hCAFE_F00D, 2'b00};
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_ar", {mBus.arvalid, mBus.arprot, mBus.araddr, s1Bus.arready, s0Bus.arready},
                  {1'b1, 3'b010, 32'h0000_3000, 2'b00});
    end
    mBus.arready = 1'b1;
    #1;
    checkOutput("stall_ar_release", {s1Bus.arready, s0Bus.arready}, 2'b10);
    @(negedge clk);
    s1Bus.arvalid = 1'b0;
    s1Bus.rready  = 1'b0;
    mBus.rvalid   = 1'b1;
    mBus.rdata    = 32'hCAFE_F00D;
    mBus.rresp    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_r", {s1Bus.rvalid, s1Bus.rdata, mBus.rready}, {1'b1, 32'hCAFE_F00D, 1'b0});
      if (mBus.rvalid && mBus.rready) xferCount++;
      @(negedge clk);
    end
    s1Bus.rready = 1'b1;
    collectResponse(2);
    @(negedge clk);
    mBus.rvalid = 1'b0;
    #1;
    checkIdle("idle_after_stall");
    checkOutput("single_transfer", xferCount, 1);

    // Reset asserted while the DATA phase is stalled; the read is abandoned.
    $display("[TB] reset mid-data sequence");
    @(negedge clk);
    s1Bus.arvalid = 1'b1;
    s1Bus.araddr  = 32'h0000_4000;
    s1Bus.rready  = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_seq_addr", mBus.arvalid, 1'b1);
    @(negedge clk);
    s1Bus.arvalid = 1'b0;
    mBus.rvalid   = 1'b1;
    mBus.rdata    = 32'h55AA_55AA;
    #1;
    checkOutput("rst_seq_data", s1Bus.rvalid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkIdle("reset_mid_data");
    mBus.rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    s1Bus.rready = 1'b1;
    #1;
    checkIdle("after_mid_reset");
    v = '{1'b1, 32'h0000_5000, 3'b000, 1'b1, 32'h0000_6000, 3'b000, 32'h0F0F_0F0F, 2'b00, 1'b0};
    applyStimulus(v);
    s1Bus.arvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
